line_event_arbiter: RTL and testbench

//  Downstream consumer of the 5-to-32 one-hot decoder outputs. Latches events on the 32 decoded

---
 rtl/line_event_arbiter_if.sv | 13 +
 rtl/line_event_arbiter.sv | 122 ++++++++++++
 tb/tb_line_event_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/line_event_arbiter_if.sv
// Valid/ready index stream carrying one decoded line index per transfer.
// The arbiter drives idx/valid through the master modport; the consumer
// drives ready through the slave modport.
interface line_event_arbiter_if #(
   parameter int W = 5
);
   logic [W-1:0] idx;
   logic         valid;
   logic         ready;

   modport master (output idx, output valid, input ready);
   modport slave  (input idx, input valid, output ready);
endinterface

// File: rtl/line_event_arbiter.sv
// Line event arbiter: latches events on N decoded lines into a sticky pending
// register, then round-robin serializes the pending lines as a flow-controlled
// stream of line indices. Events on an already-pending line are merged and
// flagged with a one-cycle drop pulse.
module line_event_arbiter #(
   parameter int N    = 32,
   parameter int W    = 5,
   parameter bit EDGE = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N-1:0]           D,
   input  logic [N-1:0]           mask,
   output logic [N-1:0]           pending,
   output logic                   drop,
   line_event_arbiter_if.master   out_if
);

   // Index arithmetic wraps modulo N so the search and pointer stay in range
   // even when N is not a power of two.
   function automatic logic [W-1:0] wrap_add(input logic [W-1:0] base,
                                             input int unsigned   off);
      int unsigned sum;
      sum = int'(base) + off;
      return W'(sum % N);
   endfunction

   logic [N-1:0] d_q;
   logic [N-1:0] pending_q, pending_d;
   logic         drop_q,    drop_d;
   logic         valid_q,   valid_d;
   logic [W-1:0] idx_q,     idx_d;
   logic [W-1:0] ptr_q,     ptr_d;

   logic         hs;
   logic [N-1:0] ev_vec;
   logic [N-1:0] set_vec;
   logic [N-1:0] clr_vec;
   logic [N-1:0] cand;
   logic [W-1:0] idx_inc;
   logic [W-1:0] start;
   logic [W-1:0] pos;
   logic         sel_found;
   logic [W-1:0] sel_idx;

   assign hs      = valid_q & out_if.ready;
   assign ev_vec  = EDGE ? (D & ~d_q) : D;
   assign set_vec = ev_vec & mask;
   assign clr_vec = hs ? ({{(N-1){1'b0}}, 1'b1} << idx_q) : '0;
   // Candidates come from the registered pending bits, so a freshly latched
   // event is only selectable one cycle after it lands in pending.
   assign cand    = pending_q & mask & ~clr_vec;
   assign idx_inc = wrap_add(idx_q, 1);
   // After a handshake the search resumes just past the line that was served.
   assign start   = hs ? idx_inc : ptr_q;

   // Round-robin search: first candidate at or above start, wrapping to 0.
   always_comb begin
      // NOTE: every signal written here gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      sel_found = 1'b0;
      sel_idx   = '0;
      pos       = '0;
      for (int k = 0; k < N; k++) begin
         pos = wrap_add(start, k);
         if (!sel_found && cand[pos]) begin
            sel_found = 1'b1;
            sel_idx   = pos;
         end
      end
   end

   // Next-state for pending, drop pulse, output register and pointer.
   always_comb begin
      // Set wins over clear on the same bit, so a line re-raised while being
      // served stays pending and is delivered again.
      pending_d = (pending_q & ~clr_vec) | set_vec;
      drop_d    = |(set_vec & pending_q & ~clr_vec);
      valid_d   = valid_q;
      idx_d     = idx_q;
      ptr_d     = hs ? idx_inc : ptr_q;
      // The output only advances when it is empty or being consumed; a stalled
      // index is never retracted, even if its mask bit drops.
      if (!valid_q || out_if.ready) begin
         if (sel_found) begin
            valid_d = 1'b1;
            idx_d   = sel_idx;
         end else begin
            valid_d = 1'b0;
         end
      end
   end

   // State registers with synchronous reset that overrides any handshake.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (!rst_n) begin
         // NOTE: clearing d_q here means a line already high when reset is
         // released is seen as a fresh edge and registers one event.
         d_q       <= '0;
         pending_q <= '0;
         drop_q    <= 1'b0;
         valid_q   <= 1'b0;
         idx_q     <= '0;
         ptr_q     <= '0;
      end else begin
         d_q       <= D;
         pending_q <= pending_d;
         drop_q    <= drop_d;
         valid_q   <= valid_d;
         idx_q     <= idx_d;
         ptr_q     <= ptr_d;
      end
   end

   assign pending      = pending_q;
   assign drop         = drop_q;
   assign out_if.valid = valid_q;
   assign out_if.idx   = idx_q;

endmodule

// File: tb/tb_line_event_arbiter.sv
// Bench for line_event_arbiter: directed scenarios plus randomized traffic,
// checked against a line-level reference model. Expected grant indices are
// queued by the stimulus side and compared by an independent handshake monitor.
module tb_line_event_arbiter;
   localparam int N = 32;
   localparam int W = 5;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] d = '0;
   logic [N-1:0] mask = '1;
   logic [N-1:0] pending;
   logic         drop;

   line_event_arbiter_if #(.W(W)) bus ();

   line_event_arbiter #(.N(N), .W(W), .EDGE(1'b1)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .D       (d),
      .mask    (mask),
      .pending (pending),
      .drop    (drop),
      .out_if  (bus)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int exp_q[$];

   // Reference model state, one entry per line.
   bit m_pend [N];
   bit m_prev [N];
   bit m_valid;
   int m_idx;
   int m_ptr;
   bit m_drop;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [N-1:0] model_pend_vec();
      logic [N-1:0] v;
      for (int i = 0; i < N; i++) v[i] = m_pend[i];
      return v;
   endfunction

   // Advance the model by one clock using the line rules directly.
   task automatic model_step(input logic [N-1:0] d_in, input logic [N-1:0] m_in,
                             input logic rdy, input logic rstv);
      bit new_pend [N];
      bit served, hs, found, nd;
      int start, j, pick;
      if (!rstv) begin
         for (int i = 0; i < N; i++) begin
            m_pend[i] = 0;
            m_prev[i] = 0;
         end
         m_valid = 0; m_idx = 0; m_ptr = 0; m_drop = 0;
         return;
      end
      hs = m_valid && rdy;
      nd = 0;
      for (int i = 0; i < N; i++) begin
         bit ev;
         ev          = d_in[i] && !m_prev[i] && m_in[i];
         served      = hs && (i == m_idx);
         new_pend[i] = (m_pend[i] && !served) || ev;
         if (ev && m_pend[i] && !served) nd = 1;
      end
      if (hs) exp_q.push_back(m_idx);
      if (!m_valid || rdy) begin
         start = hs ? (m_idx + 1) % N : m_ptr;
         found = 0;
         pick  = 0;
         for (int k = 0; k < N; k++) begin
            j = (start + k) % N;
            if (!found && m_pend[j] && m_in[j] && !(hs && j == m_idx)) begin
               found = 1;
               pick  = j;
            end
         end
         m_valid = found;
         if (found) m_idx = pick;
      end
      if (hs) m_ptr = (m_idx + 1) % N;
      for (int i = 0; i < N; i++) begin
         m_pend[i] = new_pend[i];
         m_prev[i] = d_in[i];
      end
      m_drop = nd;
   endtask

   // Apply one cycle of inputs just after a rising edge, step the model, then
   // compare registered outputs 1 time unit after the next rising edge.
   task automatic tick(input logic [N-1:0] d_in, input logic [N-1:0] m_in,
                       input logic rdy, input logic rstv);
      d         = d_in;
      mask      = m_in;
      bus.ready = rdy;
      rst_n     = rstv;
      model_step(d_in, m_in, rdy, rstv);
      @(posedge clk);
      #1;
      check("pending", pending, model_pend_vec());
      check("drop", {31'd0, drop}, {31'd0, m_drop});
      check("valid", {31'd0, bus.valid}, {31'd0, m_valid});
      check("idx", {27'd0, bus.idx}, m_idx);
   endtask

   task automatic do_reset();
      tick('0, '1, 1'b0, 1'b0);
      tick('0, '1, 1'b0, 1'b0);
   endtask

   function automatic logic [N-1:0] bit_of(input int i);
      logic [N-1:0] v;
      v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   // Handshake monitor: inputs and outputs are stable at the falling edge, so
   // a transfer about to happen on the next rising edge is visible here.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && bus.valid && bus.ready) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL hs_unexpected: got idx %0d expected no transfer at %0t", bus.idx, $time);
            end else begin
               check("hs_idx", {27'd0, bus.idx}, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      logic [N-1:0] rd, rm;
      bus.ready = 1'b1;
      @(posedge clk);
      #1;

      // Reset held with all lines high, then released with them still high.
      for (int i = 0; i < 3; i++) tick('1, '1, 1'b1, 1'b0);
      check("t1_rst_valid", {31'd0, bus.valid}, 32'd0);
      check("t1_rst_pending", pending, 32'd0);
      check("t1_rst_idx", {27'd0, bus.idx}, 32'd0);
      tick('1, '1, 1'b1, 1'b1);
      check("t1_release_pending", pending, 32'hFFFF_FFFF);
      for (int i = 0; i < 36; i++) tick('1, '1, 1'b1, 1'b1);
      tick('0, '1, 1'b1, 1'b1);

      // Single event latency.
      do_reset();
      tick(32'h0000_0400, '1, 1'b1, 1'b1);
      check("t2_pend10", pending, 32'h0000_0400);
      tick('0, '1, 1'b1, 1'b1);
      check("t2_valid", {31'd0, bus.valid}, 32'd1);
      check("t2_idx", {27'd0, bus.idx}, 32'd10);
      tick('0, '1, 1'b1, 1'b1);
      check("t2_cleared", pending, 32'd0);

      // Round-robin order from ptr=0, then re-raised lines.
      do_reset();
      tick(bit_of(3) | bit_of(7) | bit_of(31), '1, 1'b1, 1'b1);
      tick('0, '1, 1'b1, 1'b1);
      check("t3_first", {27'd0, bus.idx}, 32'd3);
      tick('0, '1, 1'b1, 1'b1);
      check("t3_second", {27'd0, bus.idx}, 32'd7);
      tick(bit_of(3) | bit_of(7), '1, 1'b1, 1'b1);
      check("t3_third", {27'd0, bus.idx}, 32'd31);
      for (int i = 0; i < 4; i++) tick('0, '1, 1'b1, 1'b1);

      // Backpressure holds the presented index.
      do_reset();
      tick(bit_of(5) | bit_of(6), '1, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) begin
         tick('0, '1, 1'b0, 1'b1);
         check("t4_hold", {27'd0, bus.idx}, 32'd5);
      end
      tick('0, '1, 1'b1, 1'b1);
      check("t4_next", {27'd0, bus.idx}, 32'd6);
      tick('0, '1, 1'b1, 1'b1);
      tick('0, '1, 1'b1, 1'b1);

      // Merge on an unserved line, then an edge coinciding with its transfer.
      do_reset();
      tick(bit_of(9), '1, 1'b0, 1'b1);
      tick('0, '1, 1'b0, 1'b1);
      tick(bit_of(9), '1, 1'b0, 1'b1);
      check("t5_drop", {31'd0, drop}, 32'd1);
      tick('0, '1, 1'b0, 1'b1);
      check("t5_drop_pulse", {31'd0, drop}, 32'd0);
      tick(bit_of(9), '1, 1'b1, 1'b1);
      check("t5_repend", pending, bit_of(9));
      check("t5_no_drop", {31'd0, drop}, 32'd0);
      for (int i = 0; i < 3; i++) tick('0, '1, 1'b1, 1'b1);

      // Masked lines.
      do_reset();
      tick(bit_of(12), ~bit_of(12), 1'b1, 1'b1);
      check("t6_masked_pend", pending, 32'd0);
      tick('0, ~bit_of(12), 1'b1, 1'b1);
      check("t6_masked_valid", {31'd0, bus.valid}, 32'd0);
      tick(bit_of(20), '1, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) begin
         tick('0, ~bit_of(20), 1'b1, 1'b1);
         check("t6_no_grant", {31'd0, bus.valid}, 32'd0);
      end
      tick('0, '1, 1'b1, 1'b1);
      check("t6_unmask_idx", {27'd0, bus.idx}, 32'd20);
      tick('0, '1, 1'b1, 1'b1);

      // Randomized traffic with occasional resets.
      for (int c = 0; c < 3000; c++) begin
         rd = $urandom & $urandom & $urandom;
         rm = ~($urandom & $urandom & $urandom & $urandom);
         tick(rd, rm, ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) != 0));
      end

      // Drain and confirm every expected transfer was observed.
      for (int i = 0; i < 40; i++) tick('0, '1, 1'b1, 1'b1);
      check("queue_empty", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
